// File: rtl/collision_scanner_pkg.sv
// Shared definitions for the collision scanner: contact flag bit positions and FSM states.
package collision_scanner_pkg;

    // Bit positions inside the 4-bit contact flag vector
    localparam int unsigned FLAG_LEFT   = 3;
    localparam int unsigned FLAG_RIGHT  = 2;
    localparam int unsigned FLAG_BOTTOM = 1;
    localparam int unsigned FLAG_TOP    = 0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } scan_state_e;

endpackage

// File: rtl/collision_box.sv
// Combinational compare of one player box against one object box.
// Box words pack x/width in the upper half and y/height in the lower half.
module collision_box
    import collision_scanner_pkg::*;
#(
    parameter int unsigned COORD_W = 16
) (
    input  logic [2*COORD_W-1:0] p_pos,
    input  logic [2*COORD_W-1:0] p_size,
    input  logic [2*COORD_W-1:0] o_pos,
    input  logic [2*COORD_W-1:0] o_size,
    input  logic                 o_valid,
    output logic [3:0]           flags,
    output logic                 overlap
);

    // One extra bit keeps every edge sum exact near the top of the coordinate range
    logic [COORD_W:0] px, py, pw, ph;
    logic [COORD_W:0] ox, oy, ow, oh;

    assign px = {1'b0, p_pos[2*COORD_W-1:COORD_W]};
    assign py = {1'b0, p_pos[COORD_W-1:0]};
    assign pw = {1'b0, p_size[2*COORD_W-1:COORD_W]};
    assign ph = {1'b0, p_size[COORD_W-1:0]};
    assign ox = {1'b0, o_pos[2*COORD_W-1:COORD_W]};
    assign oy = {1'b0, o_pos[COORD_W-1:0]};
    assign ow = {1'b0, o_size[2*COORD_W-1:COORD_W]};
    assign oh = {1'b0, o_size[COORD_W-1:0]};

    // Edge tests; touching edges count as contact
    always_comb begin
        flags              = '0;
        flags[FLAG_LEFT]   = (px <= ox + ow);
        flags[FLAG_RIGHT]  = (px + pw >= ox);
        flags[FLAG_BOTTOM] = (py <= oy + oh);
        flags[FLAG_TOP]    = (py + ph >= oy);
        overlap            = o_valid & (&flags);
    end

endmodule

// File: rtl/collision_scanner.sv
// Sequential collision engine: scans a latched player box against an object table,
// one entry per clock, and reports overlap mask, count and the first contact.
module collision_scanner
    import collision_scanner_pkg::*;
#(
    parameter int unsigned N_OBJ   = 8,
    parameter int unsigned COORD_W = 16,
    parameter int unsigned IDX_W   = $clog2(N_OBJ)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_addr,
    input  logic                 wr_valid,
    input  logic [2*COORD_W-1:0] wr_pos,
    input  logic [2*COORD_W-1:0] wr_size,
    input  logic                 start,
    input  logic [2*COORD_W-1:0] p_pos,
    input  logic [2*COORD_W-1:0] p_size,
    output logic                 busy,
    output logic                 done,
    output logic                 hit_any,
    output logic [N_OBJ-1:0]     hit_mask,
    output logic [IDX_W:0]       hit_count,
    output logic [IDX_W-1:0]     first_idx,
    output logic [3:0]           first_flags
);

    logic [2*COORD_W-1:0] tbl_pos  [N_OBJ];
    logic [2*COORD_W-1:0] tbl_size [N_OBJ];
    logic [N_OBJ-1:0]     tbl_valid;

    scan_state_e          state;
    logic [IDX_W-1:0]     idx;
    logic [2*COORD_W-1:0] pl_pos;
    logic [2*COORD_W-1:0] pl_size;

    logic [3:0]           cur_flags;
    logic                 cur_overlap;

    // Object table; a write lands at the edge, so an entry evaluated on that same edge
    // still sees its previous contents
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tbl_valid <= '0;
            for (int k = 0; k < int'(N_OBJ); k++) begin
                tbl_pos[k]  <= '0;
                tbl_size[k] <= '0;
            end
        end else if (wr_en) begin
            tbl_valid[wr_addr] <= wr_valid;
            tbl_pos[wr_addr]   <= wr_pos;
            tbl_size[wr_addr]  <= wr_size;
        end
    end

    collision_box #(
        .COORD_W (COORD_W)
    ) u_box (
        .p_pos   (pl_pos),
        .p_size  (pl_size),
        .o_pos   (tbl_pos[idx]),
        .o_size  (tbl_size[idx]),
        .o_valid (tbl_valid[idx]),
        .flags   (cur_flags),
        .overlap (cur_overlap)
    );

    // Scan FSM with registered status and result outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            idx         <= '0;
            pl_pos      <= '0;
            pl_size     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hit_any     <= 1'b0;
            hit_mask    <= '0;
            hit_count   <= '0;
            first_idx   <= '0;
            first_flags <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    done <= 1'b0;
                    // Starts during the done pulse are dropped, not queued
                    if (start && !done) begin
                        state       <= StScan;
                        busy        <= 1'b1;
                        idx         <= '0;
                        pl_pos      <= p_pos;
                        pl_size     <= p_size;
                        hit_any     <= 1'b0;
                        hit_mask    <= '0;
                        hit_count   <= '0;
                        first_idx   <= '0;
                        first_flags <= '0;
                    end
                end
                StScan: begin
                    if (cur_overlap) begin
                        hit_mask[idx] <= 1'b1;
                        hit_count     <= hit_count + (IDX_W + 1)'(1);
                        hit_any       <= 1'b1;
                        if (!hit_any) begin
                            first_idx   <= idx;
                            first_flags <= cur_flags;
                        end
                    end
                    if (idx == IDX_W'(N_OBJ - 1)) begin
                        state <= StDone;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                StDone: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collision_scanner.sv
// Directed bench for collision_scanner with a per-cycle reference model.
module tb_collision_scanner;

    localparam int N  = 8;
    localparam int C  = 16;
    localparam int IW = 3;

    logic            clock;
    logic            reset;
    logic            wr_en;
    logic [IW-1:0]   wr_addr;
    logic            wr_valid;
    logic [2*C-1:0]  wr_pos;
    logic [2*C-1:0]  wr_size;
    logic            start;
    logic [2*C-1:0]  p_pos;
    logic [2*C-1:0]  p_size;
    logic            busy;
    logic            done;
    logic            hit_any;
    logic [N-1:0]    hit_mask;
    logic [IW:0]     hit_count;
    logic [IW-1:0]   first_idx;
    logic [3:0]      first_flags;

    collision_scanner #(
        .N_OBJ   (N),
        .COORD_W (C),
        .IDX_W   (IW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_valid    (wr_valid),
        .wr_pos      (wr_pos),
        .wr_size     (wr_size),
        .start       (start),
        .p_pos       (p_pos),
        .p_size      (p_size),
        .busy        (busy),
        .done        (done),
        .hit_any     (hit_any),
        .hit_mask    (hit_mask),
        .hit_count   (hit_count),
        .first_idx   (first_idx),
        .first_flags (first_flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [2*C-1:0] m_pos  [N];
    logic [2*C-1:0] m_size [N];
    bit             m_valid[N];
    bit             m_busy = 0;
    bit             m_done = 0;
    int             m_cnt  = 0;
    logic [2*C-1:0] s_ppos, s_psize;
    logic [N-1:0]   e_mask  = '0;
    int             e_count = 0;
    int             e_first = 0;
    logic [3:0]     e_flags = '0;

    // Contact flags straight from the edge inequalities, in plain integer arithmetic
    function automatic logic [3:0] box_flags(input logic [2*C-1:0] pp, ps, op, os);
        int px, py, pw, ph, ox, oy, ow, oh;
        px = int'(pp[31:16]); py = int'(pp[15:0]);
        pw = int'(ps[31:16]); ph = int'(ps[15:0]);
        ox = int'(op[31:16]); oy = int'(op[15:0]);
        ow = int'(os[31:16]); oh = int'(os[15:0]);
        return {px <= ox + ow, px + pw >= ox, py <= oy + oh, py + ph >= oy};
    endfunction

    initial begin
        for (int k = 0; k < N; k++) begin
            m_valid[k] = 0; m_pos[k] = '0; m_size[k] = '0;
        end
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                for (int k = 0; k < N; k++) begin
                    m_valid[k] = 0; m_pos[k] = '0; m_size[k] = '0;
                end
                m_busy = 0; m_done = 0; m_cnt = 0;
                e_mask = '0; e_count = 0; e_first = 0; e_flags = '0;
            end else begin
                if (m_busy) begin
                    // Entry k is judged at the (k+1)th edge after the accepting edge
                    m_cnt++;
                    if (m_cnt <= N) begin
                        automatic int k = m_cnt - 1;
                        automatic logic [3:0] fl = box_flags(s_ppos, s_psize, m_pos[k], m_size[k]);
                        if (m_valid[k] && fl == 4'hF) begin
                            e_mask[k] = 1'b1;
                            if (e_count == 0) begin
                                e_first = k; e_flags = fl;
                            end
                            e_count++;
                        end
                    end else begin
                        m_busy = 0; m_done = 1;
                    end
                end else begin
                    if (start && !m_done) begin
                        m_busy = 1; m_cnt = 0;
                        s_ppos = p_pos; s_psize = p_size;
                        e_mask = '0; e_count = 0; e_first = 0; e_flags = '0;
                    end
                    m_done = 0;
                end
                if (wr_en) begin
                    m_valid[wr_addr] = wr_valid;
                    m_pos[wr_addr]   = wr_pos;
                    m_size[wr_addr]  = wr_size;
                end
            end
        end
    end

    // Per-cycle comparison; results are only meaningful while not scanning
    initial begin
        forever begin
            @(negedge clock);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (!m_busy) begin
                chk("hit_any", hit_any, e_count > 0);
                chk("hit_mask", hit_mask, e_mask);
                chk("hit_count", hit_count, e_count);
                chk("first_idx", first_idx, e_first);
                chk("first_flags", first_flags, e_flags);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input int a, input bit v, input logic [15:0] x, y, w, h);
        wr_en = 1; wr_addr = IW'(a); wr_valid = v; wr_pos = {x, y}; wr_size = {w, h};
        tick();
        wr_en = 0;
    endtask

    task automatic run_scan(input string name, output int lat);
        start = 1;
        tick();
        start = 0;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            nvec++; nfail++;
            $display("FAIL %s_timeout: no done within 30 cycles, expected after 9", name);
        end
    endtask

    task automatic expect_res(input string name, input int lat, input logic [7:0] mask,
                              input int cnt, input int fidx, input logic [3:0] fl);
        chk({name, "_latency"}, lat, 9);
        chk({name, "_any"}, hit_any, cnt > 0);
        chk({name, "_mask"}, hit_mask, mask);
        chk({name, "_count"}, hit_count, cnt);
        chk({name, "_first_idx"}, first_idx, fidx);
        chk({name, "_first_flags"}, first_flags, fl);
    endtask

    int lat;
    int ndone;

    initial begin
        reset = 1; start = 0; wr_en = 0; wr_addr = '0; wr_valid = 0;
        wr_pos = '0; wr_size = '0; p_pos = '0; p_size = '0;
        #23;
        tick();
        reset = 0;
        tick();

        // Empty table
        p_pos = {16'd120, 16'd40}; p_size = {16'd10, 16'd20};
        run_scan("empty", lat);
        expect_res("empty", lat, 8'h00, 0, 0, 4'h0);

        // Single overlap in entry 3
        wr(3, 1, 16'd100, 16'd50, 16'd40, 16'd10);
        run_scan("single", lat);
        expect_res("single", lat, 8'h08, 1, 3, 4'b1111);

        // Two overlaps plus a one-unit x gap; entry 5 only touches on x
        wr(3, 0, 16'd100, 16'd50, 16'd40, 16'd10);
        wr(2, 1, 16'd205, 16'd195, 16'd20, 16'd20);
        wr(5, 1, 16'd210, 16'd200, 16'd5, 16'd5);
        wr(6, 1, 16'd211, 16'd200, 16'd5, 16'd5);
        p_pos = {16'd200, 16'd200}; p_size = {16'd10, 16'd10};
        run_scan("pair", lat);
        expect_res("pair", lat, 8'h24, 2, 2, 4'b1111);

        // Sums beyond the coordinate width must not wrap
        wr(2, 0, 16'd0, 16'd0, 16'd0, 16'd0);
        wr(5, 0, 16'd0, 16'd0, 16'd0, 16'd0);
        wr(6, 0, 16'd0, 16'd0, 16'd0, 16'd0);
        wr(0, 1, 16'hFFF0, 16'd0, 16'h0020, 16'd10);
        p_pos = {16'hFFFF, 16'd0}; p_size = {16'd1, 16'd1};
        run_scan("wrap", lat);
        expect_res("wrap", lat, 8'h01, 1, 0, 4'b1111);
        wr(0, 0, 16'hFFF0, 16'd0, 16'h0020, 16'd10);
        run_scan("wrap_invalid", lat);
        expect_res("wrap_invalid", lat, 8'h00, 0, 0, 4'h0);

        // Mid-scan start, player change and write to an already-scanned entry are ignored
        wr(1, 1, 16'd50, 16'd50, 16'd20, 16'd20);
        p_pos = {16'd55, 16'd55}; p_size = {16'd5, 16'd5};
        start = 1;
        tick();
        start = 0;
        tick();
        start = 1; p_pos = {16'd900, 16'd900};
        tick();
        start = 0;
        tick();
        wr(0, 1, 16'd55, 16'd55, 16'd10, 16'd10);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) begin
                ndone++;
                chk("mid_mask", hit_mask, 8'h02);
                chk("mid_count", hit_count, 1);
                chk("mid_first_idx", first_idx, 1);
                if (ndone == 1) begin
                    start = 1;
                    tick();
                    start = 0;
                    chk("start_in_done_ignored", busy, 0);
                end
            end
        end
        chk("mid_done_pulses", ndone, 1);

        // The late write to entry 0 is visible to the following scan
        p_pos = {16'd55, 16'd55};
        run_scan("after_write", lat);
        expect_res("after_write", lat, 8'h03, 2, 0, 4'b1111);

        // Reset four cycles into a scan
        start = 1;
        tick();
        start = 0;
        tick(); tick(); tick(); tick();
        reset = 1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_any", hit_any, 0);
        chk("rst_mask", hit_mask, 0);
        chk("rst_count", hit_count, 0);
        chk("rst_first_idx", first_idx, 0);
        chk("rst_first_flags", first_flags, 0);
        tick();
        reset = 0;
        tick();
        run_scan("post_reset", lat);
        expect_res("post_reset", lat, 8'h00, 0, 0, 4'h0);

        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
